// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder on word RAM; rsp_valid rises LATENCY edges after accept (accept edge counted).
// Response held stable under rsp_ready back-pressure, req_ready only in IDLE; DMEM_RANGE_CHECK_EN adds address error checks.
module dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               accept, enter_resp;

   logic               lat_we;
   logic [IDX_W-1:0]   lat_idx;
   logic [31:0]        lat_wdata;
   logic [3:0]         lat_wstrb;

   logic [IDX_W-1:0]   req_idx;
   logic               req_err;
   logic               acc_we;
   logic [IDX_W-1:0]   acc_idx;
   logic [31:0]        acc_wdata;
   logic [3:0]         acc_wstrb;
   logic               acc_err;
   logic               wr_en;
   logic [31:0]        rdata_q;

   logic [31:0]        mem [DEPTH];

   assign req_idx = req_addr[IDX_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
   localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH);
   logic lat_err;
   logic err_q;

   assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:2] >= DEPTH_LIM);
   assign acc_err = (LATENCY == 1) ? req_err : lat_err;
   assign rsp_err = err_q;
`else
   // Index wraps modulo DEPTH; the remaining address bits carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
   assign req_err  = 1'b0;
   assign acc_err  = req_err;
   assign rsp_err  = 1'b0;
`endif

   // With LATENCY=1 the access happens on the accept edge, so it uses the live request.
   always_comb begin
      acc_we    = lat_we;
      acc_idx   = lat_idx;
      acc_wdata = lat_wdata;
      acc_wstrb = lat_wstrb;
      if (LATENCY == 1) begin
         acc_we    = req_we;
         acc_idx   = req_idx;
         acc_wdata = req_wdata;
         acc_wstrb = req_wstrb;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      accept     = 1'b0;
      enter_resp = 1'b0;
      req_ready  = (state == IDLE);
      rsp_valid  = (state == RESP);
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  enter_resp = 1'b1;
                  state_nxt  = RESP;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_W'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) begin
               enter_resp = 1'b1;
               state_nxt  = RESP;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         rdata_q   <= '0;
`ifdef DMEM_RANGE_CHECK_EN
         lat_err   <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            lat_we    <= req_we;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
`ifdef DMEM_RANGE_CHECK_EN
            lat_err   <= req_err;
`endif
         end
         if (enter_resp) begin
            rdata_q <= (acc_we || acc_err) ? 32'h0 : mem[acc_idx];
`ifdef DMEM_RANGE_CHECK_EN
            err_q   <= acc_err;
`endif
         end
      end
   end

   assign rsp_rdata = rdata_q;

   // reset_n gating keeps a LATENCY=1 store presented during reset from reaching RAM.
   assign wr_en = enter_resp && acc_we && !acc_err && reset_n;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main sequence and a LATENCY=1 instance for throughput.
// Expected responses are queued when each request is driven and popped when the response appears.
module tb_dmem_responder;
   localparam int LAT = 2;

   logic        clk;
   logic        reset_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic        req_valid1, req_ready1, req_we1;
   logic [31:0] req_addr1, req_wdata1;
   logic [3:0]  req_wstrb1;
   logic        rsp_valid1, rsp_ready1, rsp_err1;
   logic [31:0] rsp_rdata1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [32:0] exp_q[$];
   logic [32:0] exp1_q[$];

   dmem_responder #(.DEPTH(64), .LATENCY(LAT), .ADDR_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DEPTH(64), .LATENCY(1), .ADDR_W(32)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
      .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wstrb(req_wstrb1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction on the LATENCY=2 instance, with optional response back-pressure.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [31:0] exp_rdata, input logic exp_err,
                      input int bp);
      int          edges;
      logic [32:0] e;
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = wstrb;
      exp_q.push_back({exp_err, exp_rdata});
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      edges = 1;
      while (!rsp_valid && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check("latency", 32'(edges), 32'(LAT));
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rdata", rsp_rdata, e[31:0]);
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      check("rdata", rsp_rdata, e[31:0]);
      check("err", 32'(rsp_err), 32'(e[32]));
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("post_hs_valid", 32'(rsp_valid), 32'd0);
      check("post_hs_req_ready", 32'(req_ready), 32'd1);
      check("post_hs_rdata_hold", rsp_rdata, e[31:0]);
   endtask

   initial begin
      int          cyc, acc_cyc, idx, done;
      logic [32:0] e;
      logic [31:0] l1_addr [4];
      logic [31:0] l1_wdata [4];
      logic        l1_we [4];
      logic [31:0] l1_exp [4];

      reset_n    = 1'b0;
      req_valid  = 1'b0; req_we  = 1'b0; req_addr  = '0; req_wdata  = '0; req_wstrb  = '0;
      rsp_ready  = 1'b0;
      req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_wstrb1 = '0;
      rsp_ready1 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      reset_n = 1'b1;

      txn(1'b1, 32'h20, 32'h0,        4'hF, 32'h0,        1'b0, 0);
      txn(1'b1, 32'h54, 32'h47,       4'hF, 32'h0,        1'b0, 0);
      txn(1'b0, 32'h54, 32'h0,        4'hF, 32'h47,       1'b0, 0);
      txn(1'b1, 32'h54, 32'hDEAD,     4'h0, 32'h0,        1'b0, 0);
      txn(1'b0, 32'h54, 32'h0,        4'h0, 32'h47,       1'b0, 0);
      txn(1'b1, 32'h10, 32'hAABBCCDD, 4'hF, 32'h0,        1'b0, 0);
      txn(1'b1, 32'h10, 32'h11223344, 4'h5, 32'h0,        1'b0, 0);
      txn(1'b0, 32'h10, 32'h0,        4'hF, 32'hAA22CC44, 1'b0, 5);

      // Store abandoned by reset while in WAIT: outputs clear at once and RAM stays untouched.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("midop_in_wait", 32'(rsp_valid | req_ready), 32'd0);
      reset_n = 1'b0;
      #1;
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_rsp_rdata", rsp_rdata, 32'h0);
      check("midrst_rsp_err", 32'(rsp_err), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      txn(1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, 0);

`ifdef DMEM_RANGE_CHECK_EN
      txn(1'b1, 32'h4,   32'h5,  4'hF, 32'h0, 1'b0, 0);
      txn(1'b1, 32'h104, 32'h99, 4'hF, 32'h0, 1'b1, 0);
      txn(1'b0, 32'h4,   32'h0,  4'hF, 32'h5, 1'b0, 0);
      txn(1'b0, 32'h102, 32'h0,  4'hF, 32'h0, 1'b1, 0);
      txn(1'b0, 32'h100, 32'h0,  4'hF, 32'h0, 1'b1, 0);
      txn(1'b0, 32'h4,   32'h0,  4'hF, 32'h5, 1'b0, 0);
`else
      txn(1'b1, 32'h104, 32'h5, 4'hF, 32'h0, 1'b0, 0);
      txn(1'b0, 32'h4,   32'h0, 4'hF, 32'h5, 1'b0, 0);
      txn(1'b0, 32'h106, 32'h0, 4'hF, 32'h5, 1'b0, 0);
`endif

      // LATENCY=1 instance: rsp_ready tied high, request held valid, one transaction every 2 cycles.
      l1_we[0] = 1'b1; l1_addr[0] = 32'h0; l1_wdata[0] = 32'h12345678; l1_exp[0] = 32'h0;
      l1_we[1] = 1'b1; l1_addr[1] = 32'h8; l1_wdata[1] = 32'hCAFEF00D; l1_exp[1] = 32'h0;
      l1_we[2] = 1'b0; l1_addr[2] = 32'h0; l1_wdata[2] = 32'h0;        l1_exp[2] = 32'h12345678;
      l1_we[3] = 1'b0; l1_addr[3] = 32'h8; l1_wdata[3] = 32'h0;        l1_exp[3] = 32'hCAFEF00D;
      rsp_ready1 = 1'b1;
      cyc = 0; acc_cyc = 0; idx = 0; done = 0;
      while (done < 4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid1) begin
            e = (exp1_q.size() != 0) ? exp1_q.pop_front() : 33'h0;
            check("l1_rdata", rsp_rdata1, e[31:0]);
            check("l1_err", 32'(rsp_err1), 32'(e[32]));
            check("l1_gap", 32'(cyc - acc_cyc), 32'd1);
            done++;
         end
         if (req_ready1 && idx < 4) begin
            req_valid1 = 1'b1;
            req_we1    = l1_we[idx];
            req_addr1  = l1_addr[idx];
            req_wdata1 = l1_wdata[idx];
            req_wstrb1 = 4'hF;
            exp1_q.push_back({1'b0, l1_exp[idx]});
            acc_cyc = cyc;
            idx++;
         end
      end
      req_valid1 = 1'b0;
      check("l1_total_cycles", 32'(cyc), 32'd8);
      @(negedge clk);
      check("l1_idle_after", 32'(req_ready1), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
